// File: rtl/legv8_pkg.sv
`default_nettype none
// ============================================================================
// Module      : legv8_pkg
// Description : Shared LEGv8 decode constants. Holds the opcode patterns, the
//               ALUCtl codes, the instruction field positions, the XZR/link
//               register indices, a decoded-operation enum and the opcode
//               classifier used by instruction_decode.
// Config      : INSTRUCTION_DECODE_BL_EN (consumed by instruction_decode,
//               passed into decode_op through its bl_en argument)
// Revision    : 1.0 - initial release
// ============================================================================
package legv8_pkg;

    // 11-bit opcodes, instruction[31:21]
    localparam logic [10:0] OPC_HALT = 11'b11111111111;
    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [10:0] OPC_BR   = 11'b11010110000;
    // 10-bit opcodes, instruction[31:22]
    localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
    localparam logic [9:0]  OPC_SUBI = 10'b1101000100;
    // 8-bit opcodes, instruction[31:24]
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
    localparam logic [7:0]  OPC_CBNZ = 8'b10110101;
    // 6-bit opcodes, instruction[31:26]
    localparam logic [5:0]  OPC_B    = 6'b000101;
    localparam logic [5:0]  OPC_BL   = 6'b100101;

    // ALUCtl codes
    localparam logic [3:0]  ALU_AND  = 4'b0000;
    localparam logic [3:0]  ALU_ORR  = 4'b0001;
    localparam logic [3:0]  ALU_ADD  = 4'b0010;
    localparam logic [3:0]  ALU_SUB  = 4'b0110;
    localparam logic [3:0]  ALU_PASS = 4'b0111;

    // Field positions
    localparam int RD_MSB    = 4;
    localparam int RD_LSB    = 0;
    localparam int RN_MSB    = 9;
    localparam int RN_LSB    = 5;
    localparam int RM_MSB    = 20;
    localparam int RM_LSB    = 16;
    localparam int IMM12_MSB = 21;
    localparam int IMM12_LSB = 10;
    localparam int ADDR9_MSB = 20;
    localparam int ADDR9_LSB = 12;
    localparam int IMM19_MSB = 23;
    localparam int IMM19_LSB = 5;
    localparam int IMM26_MSB = 25;
    localparam int IMM26_LSB = 0;

    localparam logic [4:0] XZR      = 5'd31;
    localparam logic [4:0] LINK_REG = 5'd30;

    typedef enum logic [3:0] {
        OP_ILLEGAL = 4'd0,
        OP_HALT    = 4'd1,
        OP_ADD     = 4'd2,
        OP_SUB     = 4'd3,
        OP_AND     = 4'd4,
        OP_ORR     = 4'd5,
        OP_LDUR    = 4'd6,
        OP_STUR    = 4'd7,
        OP_BR      = 4'd8,
        OP_ADDI    = 4'd9,
        OP_SUBI    = 4'd10,
        OP_CBZ     = 4'd11,
        OP_CBNZ    = 4'd12,
        OP_B       = 4'd13,
        OP_BL      = 4'd14
    } op_e;

    // Longest opcode first: HALT, then 11/10/8/6-bit patterns.
    function automatic op_e decode_op(input logic [31:0] instr, input logic bl_en);
        op_e op;
        op = OP_ILLEGAL;
        if (instr[31:21] == OPC_HALT)                 op = OP_HALT;
        else if (instr[31:21] == OPC_ADD)             op = OP_ADD;
        else if (instr[31:21] == OPC_SUB)             op = OP_SUB;
        else if (instr[31:21] == OPC_AND)             op = OP_AND;
        else if (instr[31:21] == OPC_ORR)             op = OP_ORR;
        else if (instr[31:21] == OPC_LDUR)            op = OP_LDUR;
        else if (instr[31:21] == OPC_STUR)            op = OP_STUR;
        else if (instr[31:21] == OPC_BR)              op = OP_BR;
        else if (instr[31:22] == OPC_ADDI)            op = OP_ADDI;
        else if (instr[31:22] == OPC_SUBI)            op = OP_SUBI;
        else if (instr[31:24] == OPC_CBZ)             op = OP_CBZ;
        else if (instr[31:24] == OPC_CBNZ)            op = OP_CBNZ;
        else if (instr[31:26] == OPC_B)               op = OP_B;
        else if (bl_en && instr[31:26] == OPC_BL)     op = OP_BL;
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module      : reg_file
// Description : 32 x 64-bit LEGv8 register file. Two asynchronous read
//               ports, a write-back port and a link port (X30 only), async
//               active-low clear, X31 reads as zero, and same-cycle bypass of
//               the write-back port onto the read ports.
// Ports       : clk, rst_n
//               rd_addr1/rd_data1, rd_addr2/rd_data2 - read ports
//               wb_en, wb_addr, wb_data              - write-back port
//               link_en, link_data                   - X30 link write
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file
    import legv8_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rd_addr1,
    output logic [63:0] rd_data1,
    input  logic [4:0]  rd_addr2,
    output logic [63:0] rd_data2,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [63:0] wb_data,
    input  logic        link_en,
    input  logic [63:0] link_data
);

    logic [63:0] regs [32];

    // Entry 31 is never written, so it stays at its cleared value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wb_en && (wb_addr != XZR)) begin
                regs[wb_addr] <= wb_data;
            end
            // Placed last so the link write wins a collision on X30.
            if (link_en) begin
                regs[LINK_REG] <= link_data;
            end
        end
    end

    // Bypass is held off during reset so a cleared file reads as zero.
    always_comb begin
        if (rd_addr1 == XZR)
            rd_data1 = '0;
        else if (rst_n && wb_en && (wb_addr == rd_addr1))
            rd_data1 = wb_data;
        else
            rd_data1 = regs[rd_addr1];
    end

    always_comb begin
        if (rd_addr2 == XZR)
            rd_data2 = '0;
        else if (rst_n && wb_en && (wb_addr == rd_addr2))
            rd_data2 = wb_data;
        else
            rd_data2 = regs[rd_addr2];
    end

endmodule
`default_nettype wire

// File: rtl/instruction_decode.sv
`default_nettype none
// ============================================================================
// Module      : instruction_decode
// Description : LEGv8 single-cycle decode stage. Decodes the instruction word,
//               reads operands from the register file, produces immediates and
//               datapath controls, and resolves B/BR/CBZ/CBNZ (and BL) so fetch
//               gets PCSrc/BranchAddress in the same cycle.
// Config      : INSTRUCTION_DECODE_BL_EN - enables BL (branch + X30 <= PC+4);
//               when undefined BL decodes as Illegal.
// Ports       : clk, rst_n; instruction, PC in; PCSrc, BranchAddress out;
//               wb_en/wb_addr/wb_data write-back in; ReadData1/2, ImmExt,
//               WriteReg, RegWrite, MemRead, MemWrite, MemToReg, ALUSrc,
//               ALUCtl, Halt, Illegal out.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_decode
    import legv8_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    input  logic [63:0] PC,
    output logic        PCSrc,
    output logic [63:0] BranchAddress,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [63:0] wb_data,
    output logic [63:0] ReadData1,
    output logic [63:0] ReadData2,
    output logic [63:0] ImmExt,
    output logic [4:0]  WriteReg,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemToReg,
    output logic        ALUSrc,
    output logic [3:0]  ALUCtl,
    output logic        Halt,
    output logic        Illegal
);

`ifdef INSTRUCTION_DECODE_BL_EN
    localparam logic BL_EN = 1'b1;
`else
    localparam logic BL_EN = 1'b0;
`endif

    op_e         op;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [4:0]  rt;
    logic [4:0]  rd2_addr;
    logic        link_en;
    // Ungated decode results; reset masks them below.
    logic        pc_src_d;
    logic        reg_write_d;
    logic        mem_read_d;
    logic        mem_write_d;
    logic        alu_src_d;
    logic [3:0]  alu_ctl_d;

    assign op       = decode_op(instruction, BL_EN);
    assign rn       = instruction[RN_MSB:RN_LSB];
    assign rm       = instruction[RM_MSB:RM_LSB];
    assign rt       = instruction[RD_MSB:RD_LSB];
    assign WriteReg = rt;

    // Stores and compare-branches need the Rt value on port 2.
    assign rd2_addr = (op == OP_STUR || op == OP_CBZ || op == OP_CBNZ) ? rt : rm;
    assign link_en  = (op == OP_BL);

    reg_file u_reg_file (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr1  (rn),
        .rd_data1  (ReadData1),
        .rd_addr2  (rd2_addr),
        .rd_data2  (ReadData2),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .link_en   (link_en),
        .link_data (PC + 64'd4)
    );

    always_comb begin
        ImmExt = '0;
        case (op)
            OP_ADDI, OP_SUBI:
                ImmExt = {52'd0, instruction[IMM12_MSB:IMM12_LSB]};
            OP_LDUR, OP_STUR:
                ImmExt = {{55{instruction[ADDR9_MSB]}}, instruction[ADDR9_MSB:ADDR9_LSB]};
            OP_CBZ, OP_CBNZ:
                ImmExt = {{43{instruction[IMM19_MSB]}}, instruction[IMM19_MSB:IMM19_LSB], 2'b00};
            OP_B, OP_BL:
                ImmExt = {{36{instruction[IMM26_MSB]}}, instruction[IMM26_MSB:IMM26_LSB], 2'b00};
            default: ;
        endcase
    end

    assign BranchAddress = (op == OP_BR) ? ReadData1 : (PC + ImmExt);

    always_comb begin
        pc_src_d    = 1'b0;
        reg_write_d = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        alu_src_d   = 1'b0;
        alu_ctl_d   = ALU_AND;
        case (op)
            OP_ADD:  begin reg_write_d = 1'b1; alu_ctl_d = ALU_ADD; end
            OP_SUB:  begin reg_write_d = 1'b1; alu_ctl_d = ALU_SUB; end
            OP_AND:  begin reg_write_d = 1'b1; alu_ctl_d = ALU_AND; end
            OP_ORR:  begin reg_write_d = 1'b1; alu_ctl_d = ALU_ORR; end
            OP_ADDI: begin reg_write_d = 1'b1; alu_src_d = 1'b1; alu_ctl_d = ALU_ADD; end
            OP_SUBI: begin reg_write_d = 1'b1; alu_src_d = 1'b1; alu_ctl_d = ALU_SUB; end
            OP_LDUR: begin
                reg_write_d = 1'b1;
                mem_read_d  = 1'b1;
                alu_src_d   = 1'b1;
                alu_ctl_d   = ALU_ADD;
            end
            OP_STUR: begin mem_write_d = 1'b1; alu_src_d = 1'b1; alu_ctl_d = ALU_ADD; end
            OP_CBZ:  begin pc_src_d = (ReadData2 == 64'd0); alu_ctl_d = ALU_PASS; end
            OP_CBNZ: begin pc_src_d = (ReadData2 != 64'd0); alu_ctl_d = ALU_PASS; end
            OP_B, OP_BL, OP_BR: pc_src_d = 1'b1;
            default: ;
        endcase
    end

    assign PCSrc    = rst_n & pc_src_d;
    assign RegWrite = rst_n & reg_write_d;
    assign MemRead  = rst_n & mem_read_d;
    assign MemToReg = rst_n & mem_read_d;
    assign MemWrite = rst_n & mem_write_d;
    assign ALUSrc   = rst_n & alu_src_d;
    assign ALUCtl   = rst_n ? alu_ctl_d : 4'b0000;
    assign Halt     = rst_n & (op == OP_HALT);
    assign Illegal  = rst_n & (op == OP_ILLEGAL);

endmodule
`default_nettype wire

// File: tb/tb_instruction_decode.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_decode
// Description : Scoreboard bench for instruction_decode. A stimulus process
//               drives one instruction per cycle and queues the expected
//               outputs from a mnemonic-level reference model; a monitor
//               compares on the falling edge.
// Config      : INSTRUCTION_DECODE_BL_EN (BL expectations follow it)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_decode;

`ifdef INSTRUCTION_DECODE_BL_EN
    localparam bit BL_ON = 1'b1;
`else
    localparam bit BL_ON = 1'b0;
`endif

    localparam int M_ILL = 0, M_HALT = 1, M_ADD = 2, M_SUB = 3, M_AND = 4, M_ORR = 5,
                   M_LDUR = 6, M_STUR = 7, M_BR = 8, M_ADDI = 9, M_SUBI = 10,
                   M_CBZ = 11, M_CBNZ = 12, M_B = 13, M_BL = 14;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instruction = '0;
    logic [63:0] PC = '0;
    logic        PCSrc;
    logic [63:0] BranchAddress;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [63:0] wb_data = '0;
    logic [63:0] ReadData1, ReadData2, ImmExt;
    logic [4:0]  WriteReg;
    logic        RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, Halt, Illegal;
    logic [3:0]  ALUCtl;

    always #5 clk = ~clk;

    instruction_decode dut (
        .clk(clk), .rst_n(rst_n), .instruction(instruction), .PC(PC),
        .PCSrc(PCSrc), .BranchAddress(BranchAddress),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .ReadData1(ReadData1), .ReadData2(ReadData2), .ImmExt(ImmExt),
        .WriteReg(WriteReg), .RegWrite(RegWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemToReg(MemToReg), .ALUSrc(ALUSrc),
        .ALUCtl(ALUCtl), .Halt(Halt), .Illegal(Illegal)
    );

    typedef struct packed {
        logic [63:0] rd1, rd2, imm, ba;
        logic [4:0]  wr;
        logic        pcsrc, regw, mrd, mwr, m2r, alusrc, halt, ill, link;
        logic [3:0]  alu;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] mregs [32];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] rdreg(input logic [4:0] idx, input logic rst,
                                          input logic wbe, input logic [4:0] wa,
                                          input logic [63:0] wd);
        if (idx == 5'd31 || !rst) return 64'd0;
        if (wbe && wa == idx) return wd;
        return mregs[idx];
    endfunction

    // Two's-complement value of an n-bit field, as a 64-bit wrap-around number.
    function automatic logic [63:0] sext(input logic [63:0] field, input int bits);
        logic [63:0] half;
        half = 64'd1 << (bits - 1);
        return (field >= half) ? field - (half << 1) : field;
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [63:0] pc,
                                   input logic rst, input logic wbe,
                                   input logic [4:0] wa, input logic [63:0] wd);
        exp_t e;
        int   mn;
        logic [4:0] r2;
        e  = '0;
        mn = M_ILL;
        if (ins[31:21] == 11'h7FF)               mn = M_HALT;
        else if (ins[31:21] == 11'b10001011000)  mn = M_ADD;
        else if (ins[31:21] == 11'b11001011000)  mn = M_SUB;
        else if (ins[31:21] == 11'b10001010000)  mn = M_AND;
        else if (ins[31:21] == 11'b10101010000)  mn = M_ORR;
        else if (ins[31:21] == 11'b11111000010)  mn = M_LDUR;
        else if (ins[31:21] == 11'b11111000000)  mn = M_STUR;
        else if (ins[31:21] == 11'b11010110000)  mn = M_BR;
        else if (ins[31:22] == 10'b1001000100)   mn = M_ADDI;
        else if (ins[31:22] == 10'b1101000100)   mn = M_SUBI;
        else if (ins[31:24] == 8'b10110100)      mn = M_CBZ;
        else if (ins[31:24] == 8'b10110101)      mn = M_CBNZ;
        else if (ins[31:26] == 6'b000101)        mn = M_B;
        else if (BL_ON && ins[31:26] == 6'b100101) mn = M_BL;

        r2    = (mn == M_STUR || mn == M_CBZ || mn == M_CBNZ) ? ins[4:0] : ins[20:16];
        e.rd1 = rdreg(ins[9:5], rst, wbe, wa, wd);
        e.rd2 = rdreg(r2, rst, wbe, wa, wd);
        e.wr  = ins[4:0];
        case (mn)
            M_ADDI, M_SUBI: e.imm = 64'(ins[21:10]);
            M_LDUR, M_STUR: e.imm = sext(64'(ins[20:12]), 9);
            M_CBZ, M_CBNZ:  e.imm = sext(64'(ins[23:5]), 19) * 4;
            M_B, M_BL:      e.imm = sext(64'(ins[25:0]), 26) * 4;
            default:        e.imm = 64'd0;
        endcase
        e.ba = (mn == M_BR) ? e.rd1 : pc + e.imm;

        e.regw   = (mn >= M_ADD && mn <= M_LDUR) || mn == M_ADDI || mn == M_SUBI;
        e.mrd    = (mn == M_LDUR);
        e.m2r    = (mn == M_LDUR);
        e.mwr    = (mn == M_STUR);
        e.alusrc = (mn == M_LDUR || mn == M_STUR || mn == M_ADDI || mn == M_SUBI);
        case (mn)
            M_ADD, M_ADDI, M_LDUR, M_STUR: e.alu = 4'b0010;
            M_SUB, M_SUBI:                 e.alu = 4'b0110;
            M_ORR:                         e.alu = 4'b0001;
            M_CBZ, M_CBNZ:                 e.alu = 4'b0111;
            default:                       e.alu = 4'b0000;
        endcase
        case (mn)
            M_B, M_BL, M_BR: e.pcsrc = 1'b1;
            M_CBZ:           e.pcsrc = (e.rd2 == 0);
            M_CBNZ:          e.pcsrc = (e.rd2 != 0);
            default:         e.pcsrc = 1'b0;
        endcase
        e.halt = (mn == M_HALT);
        e.ill  = (mn == M_ILL);
        e.link = (mn == M_BL) && rst;
        if (!rst) begin
            e.pcsrc = 0; e.regw = 0; e.mrd = 0; e.m2r = 0; e.mwr = 0;
            e.alusrc = 0; e.alu = 4'b0000; e.halt = 0; e.ill = 0;
        end
        return e;
    endfunction

    // Called one time unit after a rising edge; returns at the same phase.
    task automatic issue(input logic [31:0] ins, input logic [63:0] pc, input logic rst,
                         input logic wbe, input logic [4:0] wa, input logic [63:0] wd);
        exp_t e;
        rst_n = rst; instruction = ins; PC = pc;
        wb_en = wbe; wb_addr = wa; wb_data = wd;
        if (!rst) for (int i = 0; i < 32; i++) mregs[i] = 64'd0;
        e = model(ins, pc, rst, wbe, wa, wd);
        sb_q.push_back(e);
        @(posedge clk);
        if (rst) begin
            if (wbe && wa != 5'd31) mregs[wa] = wd;
            if (e.link) mregs[30] = pc + 64'd4;
        end
        #1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                chk("ReadData1", ReadData1, mon_e.rd1);
                chk("ReadData2", ReadData2, mon_e.rd2);
                chk("ImmExt", ImmExt, mon_e.imm);
                chk("BranchAddress", BranchAddress, mon_e.ba);
                chk("WriteReg", 64'(WriteReg), 64'(mon_e.wr));
                chk("PCSrc", 64'(PCSrc), 64'(mon_e.pcsrc));
                chk("RegWrite", 64'(RegWrite), 64'(mon_e.regw));
                chk("MemRead", 64'(MemRead), 64'(mon_e.mrd));
                chk("MemToReg", 64'(MemToReg), 64'(mon_e.m2r));
                chk("MemWrite", 64'(MemWrite), 64'(mon_e.mwr));
                chk("ALUSrc", 64'(ALUSrc), 64'(mon_e.alusrc));
                chk("ALUCtl", 64'(ALUCtl), 64'(mon_e.alu));
                chk("Halt", 64'(Halt), 64'(mon_e.halt));
                chk("Illegal", 64'(Illegal), 64'(mon_e.ill));
            end
        end
    end

    localparam logic [31:0] I_ADD  = {11'b10001011000, 5'd3, 6'd0, 5'd1, 5'd4};   // ADD X4,X1,X3
    localparam logic [31:0] I_B    = {6'b000101, 26'h3FFFFFC};                    // B -4
    localparam logic [31:0] I_CBZ  = {8'b10110100, 19'd3, 5'd2};                  // CBZ X2,#3
    localparam logic [31:0] I_CBNZ = {8'b10110101, 19'd3, 5'd2};                  // CBNZ X2,#3
    localparam logic [31:0] I_LDUR = {11'b11111000010, 9'h1F8, 2'b00, 5'd1, 5'd5}; // LDUR X5,[X1,#-8]
    localparam logic [31:0] I_STUR = {11'b11111000000, 9'h1F8, 2'b00, 5'd1, 5'd3}; // STUR X3,[X1,#-8]
    localparam logic [31:0] I_BR   = {11'b11010110000, 5'd0, 6'd0, 5'd3, 5'd0};   // BR X3
    localparam logic [31:0] I_RZR  = {11'b10001011000, 5'd31, 6'd0, 5'd31, 5'd0}; // ADD X0,XZR,XZR
    localparam logic [31:0] I_BL   = {6'b100101, 26'd0};                          // BL +0
    localparam logic [31:0] I_R30  = {11'b10001011000, 5'd31, 6'd0, 5'd30, 5'd0}; // ADD X0,X30,XZR

    initial begin
        logic [31:0] ins;
        logic [4:0]  wa;
        logic [63:0] wd;
        int          kind;
        int          guard;
        for (int i = 0; i < 32; i++) mregs[i] = 64'd0;
        @(posedge clk); #1;

        issue(32'd0, 64'd0, 1'b0, 1'b0, 5'd0, 64'd0);
        issue(32'd0, 64'd0, 1'b0, 1'b1, 5'd1, 64'd99);
        issue(32'd0, 64'd0, 1'b1, 1'b1, 5'd1, 64'd5);
        issue(32'd0, 64'd0, 1'b1, 1'b1, 5'd2, 64'd0);
        issue(32'd0, 64'd0, 1'b1, 1'b1, 5'd3, 64'd7);
        issue(I_ADD, 64'd0, 1'b1, 1'b0, 5'd0, 64'd0);
        issue(I_ADD, 64'd0, 1'b1, 1'b1, 5'd1, 64'h1234);   // bypass onto Rn
        issue(32'd0, 64'd0, 1'b1, 1'b1, 5'd1, 64'd5);
        issue(I_B,    64'h40,  1'b1, 1'b0, 5'd0, 64'd0);
        issue(I_CBZ,  64'h100, 1'b1, 1'b0, 5'd0, 64'd0);
        issue(I_CBNZ, 64'h100, 1'b1, 1'b0, 5'd0, 64'd0);
        issue(I_LDUR, 64'd0,   1'b1, 1'b0, 5'd0, 64'd0);
        issue(I_STUR, 64'd0,   1'b1, 1'b0, 5'd0, 64'd0);
        issue(I_BR,   64'h80,  1'b1, 1'b0, 5'd0, 64'd0);
        issue(32'hFFE00000, 64'd0, 1'b1, 1'b0, 5'd0, 64'd0);
        issue(32'd0,  64'd0,   1'b1, 1'b1, 5'd31, 64'd9);
        issue(I_RZR,  64'd0,   1'b1, 1'b1, 5'd31, 64'd9);
        issue(I_ADD,  64'd0,   1'b0, 1'b1, 5'd1, 64'hAA);  // reset mid-cycle, write dropped
        issue(I_ADD,  64'd0,   1'b1, 1'b0, 5'd0, 64'd0);
        issue(I_BL,   64'h20,  1'b1, 1'b1, 5'd30, 64'h77);
        issue(I_R30,  64'd0,   1'b1, 1'b0, 5'd0, 64'd0);

        for (int n = 0; n < 400; n++) begin
            ins  = $urandom;
            kind = $urandom_range(0, 14);
            case (kind)
                0:  ins[31:21] = 11'b10001011000;
                1:  ins[31:21] = 11'b11001011000;
                2:  ins[31:21] = 11'b10001010000;
                3:  ins[31:21] = 11'b10101010000;
                4:  ins[31:21] = 11'b11111000010;
                5:  ins[31:21] = 11'b11111000000;
                6:  ins[31:21] = 11'b11010110000;
                7:  ins[31:22] = 10'b1001000100;
                8:  ins[31:22] = 10'b1101000100;
                9:  ins[31:24] = 8'b10110100;
                10: ins[31:24] = 8'b10110101;
                11: ins[31:26] = 6'b000101;
                12: ins[31:26] = 6'b100101;
                13: ins[31:21] = 11'h7FF;
                default: ;
            endcase
            wa = 5'($urandom);
            if ($urandom_range(0, 3) == 0) wa = ins[9:5];
            if ($urandom_range(0, 3) == 0) wa = ins[4:0];
            wd = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
            issue(ins, {$urandom, $urandom}, 1'b1, 1'($urandom), wa, wd);
        end

        guard = 0;
        while (sb_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        if (sb_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instruction_decode.md
# instruction_decode

Instruction-decode stage of the 64-bit LEGv8 single-cycle CPU. It sits between instruction fetch and execute. It decodes the 32-bit instruction word and holds the 32×64 architectural register file. It resolves unconditional and register-compare branches, and returns `PCSrc`/`BranchAddress` to fetch in the same cycle as the instruction.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  system clock; register-file writes occur on its rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `instruction`  in  32  current instruction word (little-endian assembled by fetch)
- `PC`  in  64  byte address of `instruction`
- `PCSrc`  out  1  1 = fetch loads `BranchAddress`, 0 = fetch uses PC+4
- `BranchAddress`  out  64  branch/jump target
- `wb_en`  in  1  write-back enable from later stage
- `wb_addr`  in  5  write-back register index
- `wb_data`  in  64  write-back value
- `ReadData1`, `ReadData2`  out  64  register operands
- `ImmExt`  out  64  sign/zero-extended immediate
- `WriteReg`  out  5  destination register (Rt/Rd)
- `RegWrite`, `MemRead`, `MemWrite`, `MemToReg`, `ALUSrc`  out  1  datapath controls
- `ALUCtl`  out  4  ALU operation code
- `Halt`  out  1  HALT decoded (`instruction[31:21]` = 11'h7FF)
- `Illegal`  out  1  opcode not recognised

## Operation
- Fields: Rd/Rt=[4:0], Rn=[9:5], Rm=[20:16], imm12=[21:10], addr9=[20:12], imm19=[23:5], imm26=[25:0].
- Opcodes:
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000
  - ADDI 1001000100, SUBI 1101000100
  - LDUR 11111000010, STUR 11111000000
  - BR 11010110000
  - B 000101
  - CBZ 10110100, CBNZ 10110101
  - HALT 11111111111
  - BL 100101 (see Configuration)
- Decode priority: HALT, then 11-bit, 10-bit, 8-bit, 6-bit opcodes. Anything else sets `Illegal`; all controls are 0 and `PCSrc`=0.
- Read port 1 uses Rn. Read port 2 uses Rm for R-type and Rt for STUR/CBZ/CBNZ.
- X31 reads 0, and writes to X31 are discarded.
- ImmExt:
  - ADDI/SUBI: zero-extend imm12.
  - LDUR/STUR: sign-extend addr9.
  - CBZ/CBNZ: sign-extend imm19<<2.
  - B/BL: sign-extend imm26<<2.
  - Otherwise 0.
- ALUCtl: 0010 add (ADD/ADDI/LDUR/STUR), 0110 sub, 0000 and, 0001 orr, 0111 pass-B (CBZ/CBNZ), 0000 otherwise.
- Controls:
  - RegWrite for R-type/ADDI/SUBI/LDUR.
  - MemRead+MemToReg for LDUR.
  - MemWrite for STUR.
  - ALUSrc for ADDI/SUBI/LDUR/STUR.
- Branches:
  - B: `PCSrc`=1, target PC+ImmExt.
  - CBZ: `PCSrc` = (ReadData2==0), target PC+ImmExt.
  - CBNZ: `PCSrc` = (ReadData2!=0), target PC+ImmExt.
  - BR: `PCSrc`=1, target ReadData1.
- `BranchAddress` is always PC+ImmExt, except for BR. All arithmetic is 64-bit and wraps modulo 2^64.
- Write bypass: if `wb_en` is high and `wb_addr` (≠31) matches a read index, that read returns `wb_data` in the same cycle.

## Timing
- All outputs are combinational from `instruction`, `PC` and register state. There is zero-cycle latency, and outputs are valid before the next rising `clk`.
- Register write happens on rising `clk` when `wb_en`=1 and `rst_n`=1.
- While `rst_n`=0:
  - all 32 registers clear to 0 immediately;
  - `PCSrc`=0, all controls are 0, `Halt`=0 and `Illegal`=0;
  - `BranchAddress`, `ImmExt` and `ReadData*` still follow the decode.
- Reset asserted mid-cycle discards any pending write.

## Configuration
- `INSTRUCTION_DECODE_BL_EN` defined:
  - BL gives `PCSrc`=1, target PC+ImmExt.
  - PC+4 is written to X30 on the next rising edge through a second, internal write port.
  - If `wb_en` also targets X30 in that cycle, the link write wins.
- Not defined: BL decodes as `Illegal`.

## Structure
- Shared package `legv8_pkg`: opcode constants, ALUCtl codes, field-position constants, XZR index 31.
- One sub-module, `reg_file`: 32×64, two asynchronous read ports, write port(s), async clear, X31 hard-zero, write bypass.

## Test plan
- Reset, then X1..X3 written 5/0/7; ADD X4,X1,X3 → ReadData1=5, ReadData2=7, RegWrite=1, ALUCtl=0010, PCSrc=0.
- PC=0x40, B imm26=−4 → PCSrc=1, BranchAddress=0x30.
- CBZ on X2 (=0) with imm19=3 at PC=0x100 → PCSrc=1, target 0x10C. CBNZ on the same register → PCSrc=0.
- LDUR X5,[X1,#−8] → ImmExt=0xFFFF_FFFF_FFFF_FFF8, MemRead=MemToReg=ALUSrc=RegWrite=1. STUR → MemWrite=1, RegWrite=0.
- Instruction 0xFFE00000 → Halt=1, PCSrc=0. An unknown opcode → Illegal=1, all controls 0.
- Write X31=9, then read X31 → 0. Assert `rst_n` low mid-cycle → registers read 0 and PCSrc=0 at once. With BL_EN, BL at PC=0x20 → X30=0x24 after one edge.
